// File: rtl/signed_widen_acc_pkg.sv
// Shared widths, limits and output-state encoding for the signed widening accumulator.
// Also provides the sign-extension helper used by the adder datapath.
package signed_widen_acc_pkg;

    localparam int IN_W  = 8;
    localparam int OUT_W = 16;
    localparam int MAX_N = 256;
    localparam int CNT_W = 9;

    typedef enum logic {
        EMPTY = 1'b0,
        PEND  = 1'b1
    } out_state_t;

    function automatic logic [OUT_W-1:0] sext(input logic [IN_W-1:0] v);
        return {{(OUT_W-IN_W){v[IN_W-1]}}, v};
    endfunction

endpackage

// File: rtl/signed_widen_add.sv
// Sign-extends an 8-bit sample to the accumulator width and adds it to the running sum.
module signed_widen_add
    import signed_widen_acc_pkg::*;
(
    input  logic [OUT_W-1:0] acc,
    input  logic [IN_W-1:0]  smp,
    output logic [OUT_W-1:0] sum
);

    assign sum = acc + sext(smp);

endmodule

// File: rtl/signed_widen_acc.sv
// Sums groups of N signed 8-bit samples into a 16-bit result with a one-deep output register.
// Optional early group close via the flush port when SIGNED_WIDEN_ACC_FLUSH_EN is defined.
//
// state | meaning
// EMPTY | no result waiting, out_valid=0
// PEND  | result register holds an unconsumed group sum, out_valid=1
module signed_widen_acc
    import signed_widen_acc_pkg::*;
#(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in,
    input  logic             in_valid,
    output logic             in_ready,
`ifdef SIGNED_WIDEN_ACC_FLUSH_EN
    input  logic             flush,
`endif
    output logic [OUT_W-1:0] result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count
);

    if (N < 2 || N > MAX_N) begin : g_n_check
        $error("signed_widen_acc: N must lie in 2..%0d", MAX_N);
    end

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    out_state_t       state, state_nxt;
    logic [OUT_W-1:0] acc, acc_nxt, sum, result_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             accept, last, blocked, close;

    signed_widen_add u_add (
        .acc (acc),
        .smp (in),
        .sum (sum)
    );

    assign out_valid = (state == PEND);
    assign last      = (count == LAST_CNT);
    assign blocked   = out_valid & ~out_ready;
    assign accept    = in_valid & in_ready;

`ifdef SIGNED_WIDEN_ACC_FLUSH_EN
    // A flush with nothing buffered is a no-op; a blocked output also suppresses it so
    // a pending result is never overwritten.
    assign in_ready = ~(blocked & (last | (flush & (count != '0))));
    assign close    = (accept & last)
                    | (flush & in_ready & ~blocked & ((count != '0) | accept));
`else
    assign in_ready = ~(blocked & last);
    assign close    = accept & last;
`endif

    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        count_nxt  = count;
        result_nxt = result;
        if (close) begin
            result_nxt = accept ? sum : acc;
            acc_nxt    = '0;
            count_nxt  = '0;
        end else if (accept) begin
            acc_nxt    = sum;
            count_nxt  = count + CNT_W'(1);
        end
        unique case (state)
            EMPTY: if (close) state_nxt = PEND;
            PEND:  if (!close && out_ready) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            acc    <= '0;
            count  <= '0;
            result <= '0;
        end else begin
            state  <= state_nxt;
            acc    <= acc_nxt;
            count  <= count_nxt;
            result <= result_nxt;
        end
    end

endmodule

// File: tb/tb_signed_widen_acc.sv
// Directed self-checking bench for signed_widen_acc at N=4 and N=256.
// Flush scenario is compiled in only when SIGNED_WIDEN_ACC_FLUSH_EN is defined.
module tb_signed_widen_acc;

    logic        clk;
    logic        rst_n;

    logic [7:0]  in_d;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] result;
    logic [8:0]  count;

    logic [7:0]  in2;
    logic        in_valid2, in_ready2, out_valid2, out_ready2;
    logic [15:0] result2;
    logic [8:0]  count2;

    logic        flush, flush2;

    int nchecks;
    int nerrs;

    signed_widen_acc #(.N(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in_d),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef SIGNED_WIDEN_ACC_FLUSH_EN
        .flush     (flush),
`endif
        .result    (result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    signed_widen_acc #(.N(256)) dut256 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in2),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
`ifdef SIGNED_WIDEN_ACC_FLUSH_EN
        .flush     (flush2),
`endif
        .result    (result2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .count     (count2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] v);
        in_d     = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        nchecks++; if (result !== 16'h0000) begin nerrs++; $display("FAIL reset_result: got %h expected 0000", result); end
        nchecks++; if (out_valid !== 1'b0) begin nerrs++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        nchecks++; if (count !== 9'd0) begin nerrs++; $display("FAIL reset_count: got %0d expected 0", count); end
        nchecks++; if (in_ready !== 1'b1) begin nerrs++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(8'h70);
        nchecks++; if (out_valid !== 1'b0) begin nerrs++; $display("FAIL basic_early_valid: got %b expected 0", out_valid); end
        nchecks++; if (count !== 9'd3) begin nerrs++; $display("FAIL basic_count3: got %0d expected 3", count); end
        send(8'h70);
        nchecks++; if (out_valid !== 1'b1) begin nerrs++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
        nchecks++; if (result !== 16'h01C0) begin nerrs++; $display("FAIL basic_result: got %h expected 01c0", result); end
        nchecks++; if (count !== 9'd0) begin nerrs++; $display("FAIL basic_count0: got %0d expected 0", count); end
        tick();
        nchecks++; if (out_valid !== 1'b0) begin nerrs++; $display("FAIL basic_consumed: got %b expected 0", out_valid); end
    endtask

    task automatic test_mixed_sign();
        logic [7:0] v [4];
        v[0] = 8'h7F; v[1] = 8'h80; v[2] = 8'h01; v[3] = 8'hFF;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(v[i]);
        nchecks++; if (result !== 16'hFFFF || out_valid !== 1'b1) begin nerrs++; $display("FAIL mixed_result: got %h/%b expected ffff/1", result, out_valid); end
        for (int i = 0; i < 4; i++) send(8'h80);
        nchecks++; if (result !== 16'hFE00 || out_valid !== 1'b1) begin nerrs++; $display("FAIL neg_result: got %h/%b expected fe00/1", result, out_valid); end
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_d = 8'(i);
            tick();
            if (i == 4) begin
                nchecks++; if (result !== 16'h000A || out_valid !== 1'b1) begin nerrs++; $display("FAIL b2b_first: got %h/%b expected 000a/1", result, out_valid); end
            end
            if (i == 5) begin
                nchecks++; if (out_valid !== 1'b0 || count !== 9'd1) begin nerrs++; $display("FAIL b2b_gap: got %b/%0d expected 0/1", out_valid, count); end
            end
        end
        in_valid = 1'b0;
        nchecks++; if (result !== 16'h001A || out_valid !== 1'b1) begin nerrs++; $display("FAIL b2b_second: got %h/%b expected 001a/1", result, out_valid); end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_d      = 8'h01;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        nchecks++; if (result !== 16'h0004 || out_valid !== 1'b1) begin nerrs++; $display("FAIL bp_first: got %h/%b expected 0004/1", result, out_valid); end
        for (int i = 0; i < 3; i++) tick();
        nchecks++; if (count !== 9'd3) begin nerrs++; $display("FAIL bp_count: got %0d expected 3", count); end
        nchecks++; if (in_ready !== 1'b0) begin nerrs++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
        tick();
        tick();
        nchecks++; if (count !== 9'd3 || result !== 16'h0004 || out_valid !== 1'b1) begin nerrs++; $display("FAIL bp_hold: got %0d/%h/%b expected 3/0004/1", count, result, out_valid); end
        in_valid = 1'b0;
        #1;
        nchecks++; if (in_ready !== 1'b0) begin nerrs++; $display("FAIL bp_ready_indep: got %b expected 0", in_ready); end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        nchecks++; if (in_ready !== 1'b1) begin nerrs++; $display("FAIL bp_release: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        nchecks++; if (result !== 16'h0004 || out_valid !== 1'b1 || count !== 9'd0) begin nerrs++; $display("FAIL bp_second: got %h/%b/%0d expected 0004/1/0", result, out_valid, count); end
        tick();
        nchecks++; if (out_valid !== 1'b0) begin nerrs++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        send(8'h10);
        send(8'h10);
        nchecks++; if (count !== 9'd2) begin nerrs++; $display("FAIL rmid_count: got %0d expected 2", count); end
        #2;
        rst_n = 1'b0;
        #1;
        nchecks++; if (count !== 9'd0 || result !== 16'h0000 || out_valid !== 1'b0) begin nerrs++; $display("FAIL rmid_async: got %0d/%h/%b expected 0/0000/0", count, result, out_valid); end
        #1;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) send(8'h02);
        nchecks++; if (result !== 16'h0008 || out_valid !== 1'b1) begin nerrs++; $display("FAIL rmid_fresh: got %h/%b expected 0008/1", result, out_valid); end
        tick();
    endtask

`ifdef SIGNED_WIDEN_ACC_FLUSH_EN
    task automatic test_flush();
        out_ready = 1'b1;
        send(8'h10);
        send(8'h10);
        flush = 1'b1;
        tick();
        nchecks++; if (result !== 16'h0020 || out_valid !== 1'b1 || count !== 9'd0) begin nerrs++; $display("FAIL flush_close: got %h/%b/%0d expected 0020/1/0", result, out_valid, count); end
        tick();
        flush = 1'b0;
        nchecks++; if (out_valid !== 1'b0) begin nerrs++; $display("FAIL flush_empty: got %b expected 0", out_valid); end
    endtask
`endif

    task automatic test_n256();
        int pulses;
        out_ready2 = 1'b1;
        in_valid2  = 1'b1;
        nchecks++; if (in_ready2 !== 1'b1) begin nerrs++; $display("FAIL n256_ready: got %b expected 1", in_ready2); end
        for (int g = 0; g < 2; g++) begin
            in2    = (g == 0) ? 8'h80 : 8'h7F;
            pulses = 0;
            for (int i = 0; i < 256; i++) begin
                tick();
                if (out_valid2 === 1'b1) pulses++;
            end
            nchecks++; if (pulses != 1) begin nerrs++; $display("FAIL n256_pulses: got %0d expected 1", pulses); end
            nchecks++; if (result2 !== ((g == 0) ? 16'h8000 : 16'h7F00)) begin nerrs++; $display("FAIL n256_result%0d: got %h expected %h", g, result2, (g == 0) ? 16'h8000 : 16'h7F00); end
        end
        in_valid2 = 1'b0;
        tick();
        nchecks++; if (out_valid2 !== 1'b0 || count2 !== 9'd0) begin nerrs++; $display("FAIL n256_idle: got %b/%0d expected 0/0", out_valid2, count2); end
    endtask

    initial begin
        nchecks    = 0;
        nerrs      = 0;
        in_d       = 8'h00;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        in2        = 8'h00;
        in_valid2  = 1'b0;
        out_ready2 = 1'b1;
        flush      = 1'b0;
        flush2     = 1'b0;
        test_reset();
        test_basic();
        test_mixed_sign();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
`ifdef SIGNED_WIDEN_ACC_FLUSH_EN
        test_flush();
`endif
        test_n256();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

endmodule
